// File: rtl/miriscv_irq_ctrl.sv
// Interrupt controller for miriscv_core: latches, masks and arbitrates peripheral
// requests into INT_i/mcause_i. Define IRQ_ROUND_ROBIN_EN for rotating arbitration.
module miriscv_irq_ctrl #(
  parameter int N_IRQ = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_IRQ-1:0] irq_req_i,
  input  logic [31:0]      mie_i,
  input  logic             int_rst_i,
  output logic             int_o,
  output logic [31:0]      mcause_o,
  output logic [N_IRQ-1:0] irq_ret_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_RETURN = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [N_IRQ-1:0] pending_q;
  logic [N_IRQ-1:0] elig;
  logic [N_IRQ-1:0] cur_oh;
  logic [N_IRQ-1:0] clr;
  logic [4:0]       cur_idx_q;
  logic [4:0]       winner;
  logic             mie_unused;

  // Enable bits above N_IRQ-1 have no source behind them.
  assign mie_unused = ^mie_i;
  assign elig       = pending_q & mie_i[N_IRQ-1:0];

  always_comb begin
    for (int i = 0; i < N_IRQ; i++) cur_oh[i] = (cur_idx_q == 5'(i));
  end

  assign clr = (state_q == ST_RETURN) ? cur_oh : '0;

`ifdef IRQ_ROUND_ROBIN_EN
  logic [4:0]       last_idx_q;
  logic [N_IRQ-1:0] elig_hi;
  logic [4:0]       win_hi, win_lo;

  // Rotate by splitting into sources above last_idx and a wrap-around pass.
  always_comb begin
    win_hi = '0;
    win_lo = '0;
    for (int i = 0; i < N_IRQ; i++) elig_hi[i] = elig[i] && (5'(i) > last_idx_q);
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (elig_hi[i]) win_hi = 5'(i);
      if (elig[i])    win_lo = 5'(i);
    end
    winner = (|elig_hi) ? win_hi : win_lo;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)
      last_idx_q <= 5'(N_IRQ - 1);
    else if (state_q == ST_ACTIVE && int_rst_i)
      last_idx_q <= cur_idx_q;
  end
`else
  // Descending scan: the last hit, i.e. the lowest eligible index, wins.
  always_comb begin
    winner = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (elig[i]) winner = 5'(i);
    end
  end
`endif

  // NOTE: state is written with non-blocking assignments so every flop samples
  // the pre-edge values of the others, matching the hardware it describes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      cur_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= (pending_q | irq_req_i) & ~clr;
      if (state_q == ST_IDLE && |elig)
        cur_idx_q <= winner;
    end
  end

  // NOTE: state_d gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (|elig)     state_d = ST_ACTIVE;
      ST_ACTIVE: if (int_rst_i) state_d = ST_RETURN;
      ST_RETURN:                state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  assign int_o     = (state_q == ST_ACTIVE);
  assign busy_o    = (state_q != ST_IDLE);
  assign mcause_o  = int_o ? {1'b1, 26'b0, cur_idx_q} : 32'd0;
  assign irq_ret_o = clr;

endmodule
